multdiv_sequencer: RTL and testbench

- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Takes mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage control decode and computes the product or quotient/remainder.
- Holds busy for a fixed latency to model iterative hardware, then commits the result to HI/LO.
- The stall controller stalls any D-stage multdiv instruction while E_start or busy is high.

---
 rtl/multdiv_sequencer_pkg.sv | 41 ++++
 rtl/multdiv_sequencer_if.sv | 27 ++
 rtl/multdiv_sequencer_arith.sv | 46 ++++
 rtl/multdiv_sequencer.sv | 107 ++++++++++
 tb/tb_multdiv_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, FSM states,
// default latencies and the debug view of the sequencer.
package multdiv_defs;

    // The control unit's MULTDIVControl field uses this same encoding.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        md_state_e state;
        logic      div_zero;
        logic      overflow;
    } md_dbg_t;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    function automatic logic is_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// E-stage to multdiv unit signal bundle; master is the pipeline, slave is the unit.
interface multdiv_sequencer_if;
    import multdiv_defs::*;

    // start is a one-cycle launch strobe accepted only while busy is low; the
    // stall controller holds any new multdiv op in D while start or busy is high.
    md_op_e      op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    md_dbg_t     dbg;

    modport master (
        output op, start, a, b,
        input  busy, hi, lo, rd_data, dbg
    );

    modport slave (
        input  op, start, a, b,
        output busy, hi, lo, rd_data, dbg
    );

endinterface

// File: rtl/multdiv_sequencer_arith.sv
// Combinational 64-bit result for mult/multu/div/divu as {HI, LO}, plus the
// divide-by-zero and signed-overflow flags.
module md_arith
    import multdiv_defs::*;
(
    input  md_op_e      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_zero,
    output logic        o_overflow
);

    logic [63:0]        w_a_sx, w_b_sx, w_a_zx, w_b_zx;
    logic [31:0]        w_b_div;
    logic signed [31:0] w_sq, w_sr;
    logic [31:0]        w_uq, w_ur;

    assign w_a_sx = {{32{i_a[31]}}, i_a};
    assign w_b_sx = {{32{i_b[31]}}, i_b};
    assign w_a_zx = {32'h0, i_a};
    assign w_b_zx = {32'h0, i_b};

    assign o_div_zero = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'h0);
    assign o_overflow = (i_op == MD_DIV) && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Keep the dividers away from the undefined cases; those results are substituted below.
    assign w_b_div = (i_b == 32'h0 || o_overflow) ? 32'h1 : i_b;

    assign w_sq = $signed(i_a) / $signed(w_b_div);
    assign w_sr = $signed(i_a) % $signed(w_b_div);
    assign w_uq = i_a / w_b_div;
    assign w_ur = i_a % w_b_div;

    always_comb begin
        o_result = '0;
        case (i_op)
            MD_MULT:  o_result = w_a_sx * w_b_sx;
            MD_MULTU: o_result = w_a_zx * w_b_zx;
            MD_DIV:   o_result = o_overflow ? {32'h0, 32'h8000_0000} : {w_sr, w_sq};
            MD_DIVU:  o_result = {w_ur, w_uq};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multiply/divide sequencer: launches an op, holds busy for a fixed latency,
// then commits the pending result to HI/LO. Also serves mthi/mtlo/mfhi/mflo.
module multdiv_sequencer
    import multdiv_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    multdiv_sequencer_if.slave   md
);

    md_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_count, w_count_nx;
    logic [31:0]      r_hi, w_hi_nx;
    logic [31:0]      r_lo, w_lo_nx;
    logic [63:0]      r_pend, w_pend_nx;
    logic             r_div_zero, w_div_zero_nx;
    logic             r_overflow, w_overflow_nx;

    logic [63:0]      w_result;
    logic             w_div_zero;
    logic             w_overflow;

    md_arith u_arith (
        .i_op       (md.op),
        .i_a        (md.a),
        .i_b        (md.b),
        .o_result   (w_result),
        .o_div_zero (w_div_zero),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_pend     <= '0;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_count    <= w_count_nx;
            r_hi       <= w_hi_nx;
            r_lo       <= w_lo_nx;
            r_pend     <= w_pend_nx;
            r_div_zero <= w_div_zero_nx;
            r_overflow <= w_overflow_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_count_nx    = r_count;
        w_hi_nx       = r_hi;
        w_lo_nx       = r_lo;
        w_pend_nx     = r_pend;
        w_div_zero_nx = r_div_zero;
        w_overflow_nx = r_overflow;
        case (r_state)
            ST_IDLE: begin
                // A start strobe wins over any move-to decode of the same cycle.
                if (md.start) begin
                    if (is_arith(md.op)) begin
                        w_pend_nx     = w_result;
                        w_div_zero_nx = w_div_zero;
                        w_overflow_nx = w_overflow;
                        w_count_nx    = is_mult(md.op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        w_state_nx    = ST_RUN;
                    end
                end else if (md.op == MD_MTHI) begin
                    w_hi_nx = md.a;
                end else if (md.op == MD_MTLO) begin
                    w_lo_nx = md.a;
                end
            end
            ST_RUN: begin
                if (r_count == CNT_W'(1)) begin
                    w_state_nx = ST_IDLE;
                    w_count_nx = '0;
                    if (!r_div_zero) begin
                        w_hi_nx = r_pend[63:32];
                        w_lo_nx = r_pend[31:0];
                    end
                end else begin
                    w_count_nx = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_count_nx = '0;
            end
        endcase
    end

    assign md.busy    = (r_state == ST_RUN);
    assign md.hi      = r_hi;
    assign md.lo      = r_lo;
    assign md.rd_data = (md.op == MD_MFHI) ? r_hi :
                        (md.op == MD_MFLO) ? r_lo : 32'h0;
    assign md.dbg     = '{state: r_state, div_zero: r_div_zero, overflow: r_overflow};

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_multdiv_sequencer;
    import multdiv_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multdiv_sequencer_if md();

    multdiv_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;
    logic [63:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md.op    = MD_NONE;
        md.start = 1'b0;
        md.a     = '0;
        md.b     = '0;
    endtask

    // Reference: full-width integer arithmetic, result returned as {HI, LO}.
    function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
        longint sa, sb, q, r, mag_q;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return 64'(ua * ub);
            MD_DIV: begin
                if (b == 32'h0) return {cur_hi, cur_lo};
                mag_q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                q     = ((sa < 0) != (sb < 0)) ? -mag_q : mag_q;
                r     = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'h0) return {cur_hi, cur_lo};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        exp_q.delete();
    endtask

    // disturb: 0 none, 1 start+mtlo mid-busy, 2 start on the commit cycle
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int disturb);
        int          n;
        int          lat;
        logic [63:0] exp;
        lat = is_mult(op) ? MULT_N : DIV_N;
        exp_q.push_back(ref_result(op, a, b, exp_hi, exp_lo));
        md.op    = op;
        md.a     = a;
        md.b     = b;
        md.start = 1'b1;
        tick();
        idle_inputs();
        n = 0;
        while (md.busy === 1'b1 && n < 64) begin
            check_eq("hi_hold", {32'h0, md.hi}, {32'h0, exp_hi});
            check_eq("lo_hold", {32'h0, md.lo}, {32'h0, exp_lo});
            n++;
            if (disturb == 1 && n == 2) begin
                md.op = MD_MULT; md.a = 32'd2; md.b = 32'd2; md.start = 1'b1;
            end else if (disturb == 1 && n == 3) begin
                md.op = MD_MTLO; md.a = 32'hAAAA; md.b = '0; md.start = 1'b0;
            end else if (disturb == 2 && n == lat) begin
                md.op = MD_MULT; md.a = 32'd3; md.b = 32'd3; md.start = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
        end
        idle_inputs();
        check_eq("busy_cycles", 64'(n), 64'(lat));
        exp    = exp_q.pop_front();
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
        check_eq("busy_after", {63'h0, md.busy}, 64'h0);
        check_eq("hi_commit", {32'h0, md.hi}, {32'h0, exp_hi});
        check_eq("lo_commit", {32'h0, md.lo}, {32'h0, exp_lo});
    endtask

    task automatic move_to(input md_op_e op, input logic [31:0] a);
        md.op = op;
        md.a  = a;
        tick();
        idle_inputs();
        if (op == MD_MTHI) exp_hi = a;
        else               exp_lo = a;
        check_eq("mt_busy", {63'h0, md.busy}, 64'h0);
        check_eq("mt_hi", {32'h0, md.hi}, {32'h0, exp_hi});
        check_eq("mt_lo", {32'h0, md.lo}, {32'h0, exp_lo});
    endtask

    task automatic check_reads();
        md.op = MD_MFHI;
        #1;
        check_eq("mfhi", {32'h0, md.rd_data}, {32'h0, exp_hi});
        md.op = MD_MFLO;
        #1;
        check_eq("mflo", {32'h0, md.rd_data}, {32'h0, exp_lo});
        md.op = MD_NONE;
        #1;
        check_eq("rd_none", {32'h0, md.rd_data}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        md_op_e      rops[6];
        md_op_e      op;
        logic [31:0] ra, rb;
        rops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

        do_reset();
        check_eq("rst_busy", {63'h0, md.busy}, 64'h0);
        check_eq("rst_hi", {32'h0, md.hi}, 64'h0);
        check_eq("rst_lo", {32'h0, md.lo}, 64'h0);
        check_reads();

        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        check_eq("mult_hi_const", {32'h0, md.hi}, 64'hFFFF_FFFF);
        check_eq("mult_lo_const", {32'h0, md.lo}, 64'hFFFF_FFFA);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        check_eq("multu_hi_const", {32'h0, md.hi}, 64'h1);
        check_eq("multu_lo_const", {32'h0, md.lo}, 64'hFFFF_FFFE);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("div_lo_const", {32'h0, md.lo}, 64'hFFFF_FFFD);
        check_eq("div_hi_const", {32'h0, md.hi}, 64'hFFFF_FFFF);

        run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("divu_lo_const", {32'h0, md.lo}, 64'h7FFF_FFFC);
        check_eq("divu_hi_const", {32'h0, md.hi}, 64'h1);

        move_to(MD_MTHI, 32'h1234);
        move_to(MD_MTLO, 32'h5678);
        run_op(MD_DIVU, 32'h9999, 32'h0, 0);
        check_eq("div0_hi_const", {32'h0, md.hi}, 64'h1234);
        check_eq("div0_lo_const", {32'h0, md.lo}, 64'h5678);
        check_reads();

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("ovf_lo_const", {32'h0, md.lo}, 64'h8000_0000);
        check_eq("ovf_hi_const", {32'h0, md.hi}, 64'h0);

        // Reset asserted during the third busy cycle aborts the multiply.
        md.op = MD_MULT; md.a = 32'd7; md.b = 32'd9; md.start = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        check_eq("abort_busy_pre", {63'h0, md.busy}, 64'h1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check_eq("abort_busy", {63'h0, md.busy}, 64'h0);
        check_eq("abort_hi", {32'h0, md.hi}, 64'h0);
        check_eq("abort_lo", {32'h0, md.lo}, 64'h0);
        run_op(MD_MULT, 32'd4, 32'd5, 0);
        check_eq("mult45_lo_const", {32'h0, md.lo}, 64'd20);

        run_op(MD_DIV, 32'd1000, 32'hFFFF_FFF9, 1);
        run_op(MD_MULT, 32'h0001_0003, 32'h0002_0005, 2);
        run_op(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 0);

        for (int i = 0; i < 30; i++) begin
            op = rops[$urandom_range(0, 5)];
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if (op == MD_MTHI || op == MD_MTLO) move_to(op, ra);
            else                                run_op(op, ra, rb, int'($urandom_range(0, 2)));
        end
        check_reads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
